lc4_wb_queue_ss: RTL and testbench
==================================

# lc4_wb_queue_ss

Writeback queue for the two-pipe LC4 superscalar core. It collects register results from variable-latency producers (load return path, multi-cycle units) and drains them, oldest first, up to two per cycle, onto the two register-file write ports. Pipe A carries the older result and pipe B the younger, so the register file's "pipe B wins" rule preserves program order. It also exports a per-register pending mask that the issue logic uses to stall readers of in-flight destinations.

## Interface
- n, 16, data width
- DEPTH, 4, entry count; power of two, ≥ 2
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- gwe  in  1  global write enable; state changes only when 1
- i_enq_valid_A  in  1  enqueue slot A valid (older of the pair)
- i_enq_rd_A  in  3  slot A destination register
- i_enq_data_A  in  n  slot A result
- i_enq_valid_B  in  1  enqueue slot B valid (younger)
- i_enq_rd_B  in  3  slot B destination register
- i_enq_data_B  in  n  slot B result
- o_enq_ready  out  1  at least 2 free entries
- i_drain_en  in  1  register file may accept writes this cycle
- o_rd_A  out  3  write port A selector (oldest entry)
- o_wdata_A  out  n  write port A data
- o_rd_we_A  out  1  write port A enable
- o_rd_B  out  3  write port B selector (second-oldest entry)
- o_wdata_B  out  n  write port B data
- o_rd_we_B  out  1  write port B enable
- o_pending  out  8  bit r = 1 when any valid entry targets register r
- o_count  out  clog2(DEPTH)+1  occupied entries
- o_empty  out  1  count == 0

## Operation
- Storage: circular buffer of DEPTH entries {rd, data} with head pointer, tail pointer, and count.
- Enqueue accept: `acc = gwe & o_enq_ready`. On an accepted cycle:
  - A and B both valid: A is written at tail and B at tail+1; tail += 2.
  - Only one slot valid (either slot): that entry is written at tail; tail += 1.
  - Neither valid: no change.
- o_enq_ready is computed from the current count (DEPTH − count ≥ 2), before any drain in the same cycle. A drain does not free space for a same-cycle enqueue.
- Drain outputs (combinational from state):
  - `o_rd_we_A = i_drain_en & (count ≥ 1)`
  - `o_rd_we_B = i_drain_en & (count ≥ 2)`
  - A shows entry[head] and B shows entry[head+1], both modulo DEPTH.
- Pop: when `gwe & i_drain_en`, head advances by the number of asserted write enables (0, 1 or 2).
- Same rd in both drained entries: both enables stay asserted. The register file's B-priority rule keeps the younger value. No merging occurs inside the queue.
- Count update: `count_next = count + enq_n − pop_n`. Simultaneous enqueue and pop are legal. Count never exceeds DEPTH and never underflows.
- o_pending: OR over valid entries of onehot(rd). It reflects registered state only; same-cycle enqueues are not included.
- gwe = 0: no pointer, count or storage change. Outputs still follow the current state.
- Reset (rst_n low, asynchronous): head = tail = count = 0, storage cleared to 0. Outputs during reset: o_rd_we_A = o_rd_we_B = 0, o_rd_A = o_rd_B = 0, o_wdata_A = o_wdata_B = 0, o_pending = 0, o_count = 0, o_empty = 1, o_enq_ready = 1. A reset mid-operation discards all entries.

## Timing
- Enqueue-to-write-port latency: 1 cycle. An entry accepted at edge t appears on the write ports during cycle t+1. It commits to the register file at edge t+1 if i_drain_en and gwe are high.
- Throughput: 2 entries per cycle in and 2 entries per cycle out in steady state.
- o_enq_ready, o_pending, o_count and o_empty are pure functions of registered state, so none depend combinationally on enqueue inputs.
- Write enables depend combinationally on i_drain_en only.
- Wrap-around: all pointer arithmetic is modulo DEPTH. A pair enqueued across the wrap point (tail = DEPTH−1) places B at index 0.

## Structure
- Shared package `lc4_ss_pkg`: `REG_SEL_W = 3`, `NUM_REGS = 8`, and a `wb_entry_t` struct {rd, data}. The package is reused by the register file and issue logic.
- One natural sub-module, `lc4_wb_ptr`: the head/tail/count pointer unit with 0/1/2 increments and modulo wrap. Storage, output muxing and the pending-mask OR tree stay in the top module.
- Entries are built from the codebase's `Nbit_reg`-style flops with an asynchronous clear.

## Test plan
- Reset then idle: rst_n low → o_empty = 1, o_enq_ready = 1, both write enables 0, o_pending = 0. Enqueue A {rd 3, 0x1234} with drain_en = 0 → next cycle o_count = 1, o_pending = 0x08, o_rd_we_A = 0.
- Pair drain: enqueue A {1, 0xAAAA} and B {1, 0xBBBB}, drain_en = 1 the next cycle → o_rd_A = o_rd_B = 1, both enables high, o_wdata_B = 0xBBBB. After the edge: count = 0, o_pending = 0.
- Full / backpressure (DEPTH = 4): enqueue 2 pairs with drain off → count = 4 and o_enq_ready = 0. A further pair is ignored. Enabling drain with a simultaneous pair → 2 popped, 0 accepted, count = 2.
- Wrap-around: 3 single enqueues, 3 single pops, then pair {5, 0x0005} and {6, 0x0006} → entries land at indices 3 and 0 and drain in order A = 5, B = 6.
- gwe gating: gwe = 0 with enqueue and drain active → count and pointers unchanged while outputs still show the head entry.
- Asynchronous reset mid-stream: with count = 3, pulse rst_n low between clock edges → outputs go immediately to reset values. After release, an enqueue of {7, 0xFFFF} drains alone on port A.

Source files
------------

// File: rtl/lc4_wb_queue_ss_pkg.sv
// Shared LC4 superscalar definitions used by the writeback queue, register file and issue logic.
package lc4_ss_pkg;
    localparam int REG_SEL_W = 3;
    localparam int NUM_REGS  = 8;
    localparam int WORD_W    = 16;

    typedef struct packed {
        logic [REG_SEL_W-1:0] rd;
        logic [WORD_W-1:0]    data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_SEL_W-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction
endpackage

// File: rtl/lc4_wb_queue_ss_if.sv
// Enqueue / drain bus of the writeback queue; slave = queue side, master = pipeline side.
interface lc4_wb_queue_ss_if #(
    parameter int n     = 16,
    parameter int DEPTH = 4
);
    import lc4_ss_pkg::*;

    logic                     i_enq_valid_A;
    logic [REG_SEL_W-1:0]     i_enq_rd_A;
    logic [n-1:0]             i_enq_data_A;
    logic                     i_enq_valid_B;
    logic [REG_SEL_W-1:0]     i_enq_rd_B;
    logic [n-1:0]             i_enq_data_B;
    logic                     o_enq_ready;
    logic                     i_drain_en;
    logic [REG_SEL_W-1:0]     o_rd_A;
    logic [n-1:0]             o_wdata_A;
    logic                     o_rd_we_A;
    logic [REG_SEL_W-1:0]     o_rd_B;
    logic [n-1:0]             o_wdata_B;
    logic                     o_rd_we_B;
    logic [NUM_REGS-1:0]      o_pending;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     o_empty;

    modport slave (
        input  i_enq_valid_A, i_enq_rd_A, i_enq_data_A,
        input  i_enq_valid_B, i_enq_rd_B, i_enq_data_B, i_drain_en,
        output o_enq_ready, o_rd_A, o_wdata_A, o_rd_we_A,
        output o_rd_B, o_wdata_B, o_rd_we_B, o_pending, o_count, o_empty
    );

    modport master (
        output i_enq_valid_A, i_enq_rd_A, i_enq_data_A,
        output i_enq_valid_B, i_enq_rd_B, i_enq_data_B, i_drain_en,
        input  o_enq_ready, o_rd_A, o_wdata_A, o_rd_we_A,
        input  o_rd_B, o_wdata_B, o_rd_we_B, o_pending, o_count, o_empty
    );
endinterface

// File: rtl/lc4_wb_queue_ss_ptr.sv
// Head/tail/count pointer unit: 0/1/2 advances per cycle, modulo a power-of-two depth.
module lc4_wb_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       gwe,
    input  logic [1:0]                 enq_n_i,
    input  logic [1:0]                 pop_n_i,
    output logic [$clog2(DEPTH)-1:0]   head_o,
    output logic [$clog2(DEPTH)-1:0]   tail_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer width equals log2(DEPTH), so natural overflow is the modulo wrap.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (gwe) begin
            head_d  = head_q + PW'(pop_n_i);
            tail_d  = tail_q + PW'(enq_n_i);
            count_d = count_q + CW'(enq_n_i) - CW'(pop_n_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
endmodule

// File: rtl/lc4_wb_queue_ss_reg.sv
// N-bit register with write enable and asynchronous clear, used for queue entries.
module lc4_nbit_reg #(
    parameter int n = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we_i,
    input  logic [n-1:0] d_i,
    output logic [n-1:0] q_o
);
    logic [n-1:0] val_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    val_q <= '0;
        else if (we_i) val_q <= d_i;
    end

    assign q_o = val_q;
endmodule

// File: rtl/lc4_wb_queue_ss.sv
// Two-wide in-order writeback queue feeding both register-file write ports, with a pending-rd mask.
module lc4_wb_queue_ss
    import lc4_ss_pkg::*;
#(
    parameter int n     = 16,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic gwe,
    lc4_wb_queue_ss_if.slave wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = REG_SEL_W + n;

    logic [PW-1:0]                head, tail, head_p1, tail_p1;
    logic [CW-1:0]                count;
    logic [1:0]                   enq_n, pop_n;
    logic                         enq_ready, acc, we_a, we_b;
    logic [EW-1:0]                ent_a, ent_b;
    logic [DEPTH-1:0]             ent_we, live;
    logic [DEPTH-1:0][EW-1:0]     ent_d, ent_q;
    logic [NUM_REGS-1:0]          pend;

    lc4_wb_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .gwe     (gwe),
        .enq_n_i (enq_n),
        .pop_n_i (pop_n),
        .head_o  (head),
        .tail_o  (tail),
        .count_o (count)
    );

    assign head_p1 = head + PW'(1);
    assign tail_p1 = tail + PW'(1);

    // Ready looks only at current occupancy; a same-cycle pop does not make room.
    assign enq_ready = (count <= CW'(DEPTH - 2));
    assign acc       = gwe & enq_ready;
    assign enq_n     = acc ? ({1'b0, wb.i_enq_valid_A} + {1'b0, wb.i_enq_valid_B}) : 2'd0;

    assign we_a  = wb.i_drain_en & (count != '0);
    assign we_b  = wb.i_drain_en & (count >= CW'(2));
    assign pop_n = gwe ? ({1'b0, we_a} + {1'b0, we_b}) : 2'd0;

    assign ent_a = {wb.i_enq_rd_A, wb.i_enq_data_A};
    assign ent_b = {wb.i_enq_rd_B, wb.i_enq_data_B};

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        // A lone B slot lands at tail; a pair puts B one past tail.
        assign ent_we[i] = acc & (((wb.i_enq_valid_A | wb.i_enq_valid_B) & (tail == PW'(i))) |
                                  (wb.i_enq_valid_A & wb.i_enq_valid_B & (tail_p1 == PW'(i))));
        assign ent_d[i]  = ((tail == PW'(i)) && wb.i_enq_valid_A) ? ent_a : ent_b;
        assign off       = PW'(i) - head;
        assign live[i]   = ({1'b0, off} < count);

        lc4_nbit_reg #(.n(EW)) u_ent (
            .clk   (clk),
            .rst_n (rst_n),
            .we_i  (ent_we[i]),
            .d_i   (ent_d[i]),
            .q_o   (ent_q[i])
        );
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live[i]) pend = pend | rd_onehot(ent_q[i][EW-1 -: REG_SEL_W]);
    end

    assign {wb.o_rd_A, wb.o_wdata_A} = ent_q[head];
    assign {wb.o_rd_B, wb.o_wdata_B} = ent_q[head_p1];
    assign wb.o_rd_we_A   = we_a;
    assign wb.o_rd_we_B   = we_b;
    assign wb.o_enq_ready = enq_ready;
    assign wb.o_pending   = pend;
    assign wb.o_count     = count;
    assign wb.o_empty     = (count == '0);
endmodule

// File: tb/tb_lc4_wb_queue_ss.sv
// Bench for lc4_wb_queue_ss: directed vector table, reset corner sequence, random run against a queue model.
module tb_lc4_wb_queue_ss;
    import lc4_ss_pkg::*;

    localparam int DEPTH = 4;

    logic clk, rst_n, gwe;
    int   checks = 0;
    int   errors = 0;

    lc4_wb_queue_ss_if #(.n(16), .DEPTH(DEPTH)) wb ();

    lc4_wb_queue_ss #(.n(16), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gwe   (gwe),
        .wb    (wb)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        gwe, drain, va, vb;
        logic [2:0]  rda, rdb;
        logic [15:0] da, db;
        logic [2:0]  cnt;
        logic [7:0]  pend;
        logic        we_a, we_b, rdy;
        logic [2:0]  rd_a, rd_b;
        logic [15:0] wd_a, wd_b;
    } vec_t;

    vec_t      tbl[13];
    wb_entry_t q[$];

    function automatic vec_t mk(input int g, dr, va, rda, da, vb, rdb, db,
                                input int cnt, pend, wea, web, rd_a, wd_a, rd_b, wd_b, rdy);
        vec_t r;
        r.gwe = g[0];    r.drain = dr[0];   r.va = va[0];     r.vb = vb[0];
        r.rda = rda[2:0]; r.rdb = rdb[2:0]; r.da = da[15:0];  r.db = db[15:0];
        r.cnt = cnt[2:0]; r.pend = pend[7:0]; r.we_a = wea[0]; r.we_b = web[0];
        r.rd_a = rd_a[2:0]; r.wd_a = wd_a[15:0]; r.rd_b = rd_b[2:0]; r.wd_b = wd_b[15:0];
        r.rdy = rdy[0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic g, dr, va, input logic [2:0] rda, input logic [15:0] da,
                         input logic vb, input logic [2:0] rdb, input logic [15:0] db);
        gwe              = g;
        wb.i_drain_en    = dr;
        wb.i_enq_valid_A = va;
        wb.i_enq_rd_A    = rda;
        wb.i_enq_data_A  = da;
        wb.i_enq_valid_B = vb;
        wb.i_enq_rd_B    = rdb;
        wb.i_enq_data_B  = db;
    endtask

    task automatic idle(input logic dr);
        drive(1'b1, dr, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " count"},   32'(wb.o_count),   0);
        chk({tag, " empty"},   32'(wb.o_empty),   1);
        chk({tag, " ready"},   32'(wb.o_enq_ready), 1);
        chk({tag, " we_a"},    32'(wb.o_rd_we_A), 0);
        chk({tag, " we_b"},    32'(wb.o_rd_we_B), 0);
        chk({tag, " pending"}, 32'(wb.o_pending), 0);
        chk({tag, " rd_a"},    32'(wb.o_rd_A),    0);
        chk({tag, " wdata_a"}, 32'(wb.o_wdata_A), 0);
        chk({tag, " rd_b"},    32'(wb.o_rd_B),    0);
        chk({tag, " wdata_b"}, 32'(wb.o_wdata_B), 0);
    endtask

    initial begin
        //        g dr va rda da      vb rdb db      | cnt pend  weA weB rdA wdA     rdB wdB     rdy
        tbl[0]  = mk(1,0,0,0,0,       0,0,0,         0,0,    0,0, 0,0,       0,0,       1);
        tbl[1]  = mk(1,0,1,3,'h1234,  0,0,0,         0,0,    0,0, 0,0,       0,0,       1);
        tbl[2]  = mk(1,0,0,0,0,       0,0,0,         1,'h08, 0,0, 3,'h1234,  0,0,       1);
        tbl[3]  = mk(1,1,1,1,'hAAAA,  1,1,'hBBBB,    1,'h08, 1,0, 3,'h1234,  0,0,       1);
        tbl[4]  = mk(1,1,0,0,0,       0,0,0,         2,'h02, 1,1, 1,'hAAAA,  1,'hBBBB,  1);
        tbl[5]  = mk(1,0,1,2,'h2222,  1,4,'h4444,    0,0,    0,0, 0,0,       3,'h1234,  1);
        tbl[6]  = mk(1,0,1,5,'h5555,  1,6,'h6666,    2,'h14, 0,0, 2,'h2222,  4,'h4444,  1);
        tbl[7]  = mk(1,0,1,7,'h7777,  1,0,0,         4,'h74, 0,0, 2,'h2222,  4,'h4444,  0);
        tbl[8]  = mk(1,1,1,7,'h7777,  1,0,0,         4,'h74, 1,1, 2,'h2222,  4,'h4444,  0);
        tbl[9]  = mk(0,1,1,7,'h7777,  0,0,0,         2,'h60, 1,1, 5,'h5555,  6,'h6666,  1);
        tbl[10] = mk(1,1,0,0,0,       1,0,'h0BEE,    2,'h60, 1,1, 5,'h5555,  6,'h6666,  1);
        tbl[11] = mk(1,1,0,0,0,       0,0,0,         1,'h01, 1,0, 0,'h0BEE,  4,'h4444,  1);
        tbl[12] = mk(1,0,0,0,0,       0,0,0,         0,0,    0,0, 4,'h4444,  5,'h5555,  1);

        rst_n = 1'b0;
        idle(1'b1);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: outputs checked before the edge that applies the row's inputs.
        for (int i = 0; i < 13; i++) begin
            string t;
            @(negedge clk);
            drive(tbl[i].gwe, tbl[i].drain, tbl[i].va, tbl[i].rda, tbl[i].da,
                  tbl[i].vb, tbl[i].rdb, tbl[i].db);
            #1;
            t = $sformatf("vec%0d", i);
            chk({t, " count"},   32'(wb.o_count),     32'(tbl[i].cnt));
            chk({t, " empty"},   32'(wb.o_empty),     32'(tbl[i].cnt == 0));
            chk({t, " pending"}, 32'(wb.o_pending),   32'(tbl[i].pend));
            chk({t, " ready"},   32'(wb.o_enq_ready), 32'(tbl[i].rdy));
            chk({t, " we_a"},    32'(wb.o_rd_we_A),   32'(tbl[i].we_a));
            chk({t, " we_b"},    32'(wb.o_rd_we_B),   32'(tbl[i].we_b));
            chk({t, " rd_a"},    32'(wb.o_rd_A),      32'(tbl[i].rd_a));
            chk({t, " wdata_a"}, 32'(wb.o_wdata_A),   32'(tbl[i].wd_a));
            chk({t, " rd_b"},    32'(wb.o_rd_B),      32'(tbl[i].rd_b));
            chk({t, " wdata_b"}, 32'(wb.o_wdata_B),   32'(tbl[i].wd_b));
        end

        // Asynchronous reset with three entries in flight.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0202);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 3'd3, 16'h0303, 1'b0, 3'd0, 16'h0);
        @(negedge clk);
        idle(1'b1);
        #1;
        chk("pre-areset count", 32'(wb.o_count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("areset");
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'd7, 16'hFFFF, 1'b0, 3'd0, 16'h0);
        #1;
        chk("post-areset we_a", 32'(wb.o_rd_we_A), 0);
        @(negedge clk);
        idle(1'b1);
        #1;
        chk("lone count",   32'(wb.o_count),   1);
        chk("lone we_a",    32'(wb.o_rd_we_A), 1);
        chk("lone we_b",    32'(wb.o_rd_we_B), 0);
        chk("lone rd_a",    32'(wb.o_rd_A),    7);
        chk("lone wdata_a", 32'(wb.o_wdata_A), 32'h0000FFFF);
        chk("lone pending", 32'(wb.o_pending), 32'h80);
        @(negedge clk);
        #1;
        chk("lone drained empty", 32'(wb.o_empty), 1);

        // Random traffic against a FIFO model.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        q.delete();
        for (int c = 0; c < 1500; c++) begin
            logic g, dr, va, vb;
            logic [2:0] rda, rdb;
            logic [15:0] da, db;
            logic [7:0] pend;
            int sz, k;
            wb_entry_t ea, eb;
            @(negedge clk);
            g   = ($urandom_range(9) != 0);
            dr  = ($urandom_range(9) < 6);
            va  = 1'($urandom_range(1));
            vb  = 1'($urandom_range(1));
            rda = 3'($urandom_range(7));
            rdb = 3'($urandom_range(7));
            da  = 16'($urandom);
            db  = 16'($urandom);
            drive(g, dr, va, rda, da, vb, rdb, db);
            #1;
            sz = q.size();
            pend = '0;
            foreach (q[j]) pend[q[j].rd] = 1'b1;
            chk("rnd count",   32'(wb.o_count),     32'(sz));
            chk("rnd empty",   32'(wb.o_empty),     32'(sz == 0));
            chk("rnd ready",   32'(wb.o_enq_ready), 32'(sz <= DEPTH - 2));
            chk("rnd pending", 32'(wb.o_pending),   32'(pend));
            chk("rnd we_a",    32'(wb.o_rd_we_A),   32'(dr && sz >= 1));
            chk("rnd we_b",    32'(wb.o_rd_we_B),   32'(dr && sz >= 2));
            if (sz >= 1) begin
                chk("rnd rd_a",    32'(wb.o_rd_A),    32'(q[0].rd));
                chk("rnd wdata_a", 32'(wb.o_wdata_A), 32'(q[0].data));
            end
            if (sz >= 2) begin
                chk("rnd rd_b",    32'(wb.o_rd_B),    32'(q[1].rd));
                chk("rnd wdata_b", 32'(wb.o_wdata_B), 32'(q[1].data));
            end
            if (g) begin
                k = dr ? ((sz >= 2) ? 2 : sz) : 0;
                repeat (k) void'(q.pop_front());
                if (sz <= DEPTH - 2) begin
                    ea.rd = rda; ea.data = da;
                    eb.rd = rdb; eb.data = db;
                    if (va) q.push_back(ea);
                    if (vb) q.push_back(eb);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
